// File: rtl/alu_mdu.sv
// alu_mdu: single-issue ALU with iterative shift-add multiplier and restoring divider
module alu_mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative,
   output logic             div_by_zero
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
   logic [1:0]         state;
   logic [WIDTH-1:0]   opb, bb, sra_r, alu_res, fin_res;
   logic [3:0]         opr;
   logic [2*WIDTH-1:0] acc, nx;
   logic [SHW:0]       cnt;
   logic [WIDTH:0]     add_s, msum, rs, dd;
   logic               sub, ge, iter, calc, fin_c, fin_v, fin_z, fin_dz;
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   always_comb begin
      sub     = op == 4'b0001;
      bb      = sub ? ~b : b;
      add_s   = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(sub);
      sra_r   = $signed(a) >>> b[SHW-1:0];
      alu_res = op[3:1] == 3'b000 ? add_s[WIDTH-1:0]
              : op == 4'd2 ? a & b
              : op == 4'd3 ? a | b
              : op == 4'd4 ? a ^ b
              : op == 4'd5 ? WIDTH'($signed(a) < $signed(b))
              : op == 4'd6 ? WIDTH'(a < b)
              : op == 4'd7 ? a << b[SHW-1:0]
              : op == 4'd8 ? a >> b[SHW-1:0]
              : op == 4'd9 ? sra_r
              : {WIDTH{1'b0}};
      calc    = state == CALC;
      iter    = op[3] & (op[2] ^ op[1]);
      // mul: acc = {partial, multiplier}; div: acc = {remainder, dividend/quotient}
      msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? opb : {WIDTH{1'b0}}};
      rs      = acc[2*WIDTH-1:WIDTH-1];
      ge      = rs >= {1'b0, opb};
      dd      = rs - {1'b0, opb};
      nx      = opr[3:2] == 2'b11 ? {ge ? dd[WIDTH-1:0] : rs[WIDTH-1:0], acc[WIDTH-2:0], ge}
                                  : {msum, acc[WIDTH-1:1]};
      fin_res = calc ? (opr[0] ? nx[2*WIDTH-1:WIDTH] : nx[WIDTH-1:0]) : alu_res;
      fin_c   = ~calc & (op[3:1] == 3'b000) & add_s[WIDTH];
      fin_v   = ~calc & (op[3:1] == 3'b000) & (a[WIDTH-1] == bb[WIDTH-1]) & (add_s[WIDTH-1] != a[WIDTH-1]);
      fin_z   = (fin_res == {WIDTH{1'b0}}) & (calc | (op[3:1] != 3'b111));
      fin_dz  = calc & (opr[3:2] == 2'b11) & (opb == {WIDTH{1'b0}});
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         opb <= '0;
         opr <= '0;
         acc <= '0;
         cnt <= '0;
         result <= '0;
         {carry, overflow, zero, negative, div_by_zero} <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               opb <= b;
               opr <= op;
               cnt <= '0;
               if (iter) begin
                  acc <= {{WIDTH{1'b0}}, a};
                  state <= CALC;
               end else begin
                  result <= fin_res;
                  {carry, overflow, zero, negative, div_by_zero} <= {fin_c, fin_v, fin_z, fin_res[WIDTH-1], fin_dz};
                  state <= DONE;
               end
            end
            CALC: begin
               acc <= nx;
               cnt <= cnt + 1'b1;
               if (cnt == (SHW+1)'(WIDTH-1)) begin
                  result <= fin_res;
                  {carry, overflow, zero, negative, div_by_zero} <= {fin_c, fin_v, fin_z, fin_res[WIDTH-1], fin_dz};
                  state <= DONE;
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed self-checking bench for alu_mdu at WIDTH=32
module tb_alu_mdu;
   logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
   logic [31:0] a = 0, b = 0;
   logic [3:0]  op = 0;
   logic        in_ready, out_valid, carry, overflow, zero, negative, div_by_zero;
   logic [31:0] result;
   logic [4:0]  fl;
   int          tests = 0, fails = 0, lat;
   logic        rdy_bad;
   assign fl = {carry, overflow, zero, negative, div_by_zero};
   alu_mdu #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry(carry),
      .overflow(overflow), .zero(zero), .negative(negative), .div_by_zero(div_by_zero)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic go(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      in_valid = 1; op = o; a = x; b = y;
      tick();
      in_valid = 0; a = $urandom; b = $urandom; op = 4'($urandom);
      lat = 1; rdy_bad = 0;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_bad = 1;
         tick();
         lat++;
      end
   endtask
   task automatic handoff();
      out_ready = 1;
      tick();
      out_ready = 0;
   endtask
   // flags order: {carry, overflow, zero, negative, div_by_zero}
   task automatic expect_op(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] res, input logic [4:0] f, input int l);
      go(o, x, y);
      check({tag, "_lat"}, 64'(lat), 64'(l));
      check({tag, "_res"}, 64'(result), 64'(res));
      check({tag, "_flags"}, 64'(fl), 64'(f));
      if (l > 1) check({tag, "_ready_low"}, 64'(rdy_bad), 64'(0));
      handoff();
      check({tag, "_idle"}, 64'({out_valid, in_ready}), 64'(2'b01));
   endtask
   initial begin
      in_valid = 1;
      tick(); tick();
      in_valid = 0; rst = 0;
      check("rst_state", 64'({out_valid, in_ready}), 64'(2'b01));
      check("rst_res", 64'(result), 64'(0));
      check("rst_flags", 64'(fl), 64'(0));
      expect_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 5'b01010, 1);
      expect_op("sub_zero", 4'd1, 32'd5, 32'd5, 32'd0, 5'b10100, 1);
      expect_op("sub_borrow", 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 5'b00010, 1);
      expect_op("add_carry", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'b10100, 1);
      expect_op("sra", 4'd9, 32'h8000_0000, 32'd4, 32'hF800_0000, 5'b00010, 1);
      expect_op("srl", 4'd8, 32'h8000_0000, 32'd31, 32'd1, 5'b00000, 1);
      expect_op("sll", 4'd7, 32'd1, 32'h21, 32'd2, 5'b00000, 1);
      expect_op("xor", 4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'b00000, 1);
      expect_op("and", 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 5'b00010, 1);
      expect_op("or", 4'd3, 32'h00F0_0000, 32'h0000_000F, 32'h00F0_000F, 5'b00000, 1);
      expect_op("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 5'b00000, 1);
      expect_op("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'b00100, 1);
      expect_op("op14", 4'd14, 32'd5, 32'd5, 32'd0, 5'b00000, 1);
      expect_op("mul", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 5'b00000, 33);
      expect_op("mulhu", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'b00010, 33);
      expect_op("divu", 4'd12, 32'd100, 32'd7, 32'd14, 5'b00000, 33);
      expect_op("remu", 4'd13, 32'd100, 32'd7, 32'd2, 5'b00000, 33);
      expect_op("divu0", 4'd12, 32'd100, 32'd0, 32'hFFFF_FFFF, 5'b00011, 33);
      expect_op("remu0", 4'd13, 32'd100, 32'd0, 32'd100, 5'b00001, 33);
      go(4'd0, 32'd2, 32'd3);
      for (int i = 0; i < 5; i++) begin
         in_valid = (i == 2); op = 4'd0; a = 32'd1; b = 32'd1;
         tick();
         check("bp_hold", 64'({out_valid, in_ready, result, fl}), 64'({2'b10, 32'd5, 5'b00000}));
      end
      in_valid = 0;
      handoff();
      check("bp_handoff", 64'({out_valid, in_ready}), 64'(2'b01));
      tick();
      check("bp_dropped", 64'(out_valid), 64'(0));
      in_valid = 1; op = 4'd12; a = 32'd100; b = 32'd7;
      tick();
      in_valid = 0;
      for (int i = 0; i < 9; i++) tick();
      check("abort_in_calc", 64'({out_valid, in_ready}), 64'(2'b00));
      rst = 1;
      tick();
      rst = 0;
      check("abort_state", 64'({out_valid, in_ready}), 64'(2'b01));
      check("abort_res", 64'(result), 64'(0));
      for (int i = 0; i < 30; i++) tick();
      check("abort_no_result", 64'(out_valid), 64'(0));
      expect_op("post_rst_add", 4'd0, 32'd2, 32'd3, 32'd5, 5'b00000, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32; datapath width. Legal values are powers of two, 8 or greater.
REQ-002 Derived constant SHW = log2(WIDTH); sets the shift-amount width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operation request.
REQ-006 in_ready  out  1  block can accept a request.
REQ-007 a, b  in  WIDTH each  operands.
REQ-008 op  in  4  operation select (see REQ-013).
REQ-009 out_valid  out  1  result available.
REQ-010 out_ready  in  1  consumer accepts the result.
REQ-011 result  out  WIDTH  operation result.
REQ-012 carry, overflow, zero, negative, div_by_zero  out  1 each  status flags for the held result.

Function
REQ-013 op encoding:
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
- 0101 SLT (signed), 0110 SLTU
- 0111 SLL, 1000 SRL, 1001 SRA (amount b[SHW-1:0])
- 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned)
- 1100 DIVU, 1101 REMU
- 1110 and 1111 give result 0 with all flags 0.
REQ-014 A request is accepted on a clock edge where in_valid=1 and in_ready=1. a, b and op are captured at that edge; later changes to the inputs have no effect.
REQ-015 The FSM has three states: IDLE, CALC, DONE.
- in_ready=1 only in IDLE.
- out_valid=1 only in DONE.
REQ-016 IDLE transitions on accept:
- Non-iterative op: go to DONE. out_valid rises 1 cycle after accept.
- MUL, MULHU, DIVU, REMU: go to CALC.
REQ-017 CALC runs exactly WIDTH cycles, then goes to DONE. out_valid rises WIDTH+1 cycles after accept.
- Multiply: unsigned shift-add into a 2*WIDTH-bit accumulator.
- Divide: unsigned restoring division, one quotient bit per cycle.
REQ-018 DONE to IDLE transition occurs at the edge where out_ready=1. While out_ready=0, result and all flags hold stable for any number of cycles.
REQ-019 Maximum throughput is one operation per 2 cycles. Back-to-back accept in the same cycle as result handoff is not supported.
REQ-020 ADD/SUB flags:
- carry = carry-out of a+b (ADD) or of a+~b+1 (SUB); for SUB, carry=1 means no borrow.
- overflow = signed two's-complement overflow.
- For every other op, carry=0 and overflow=0.
REQ-021 zero = (result == 0); negative = result[WIDTH-1]. Both apply to every op.
REQ-022 SLT and SLTU return 1 or 0 in bit 0; upper bits are 0.
REQ-023 Divide by zero (b == 0 on DIVU/REMU):
- Latency is unchanged.
- DIVU gives all ones; REMU gives a.
- div_by_zero=1. div_by_zero is 0 for every other case.
REQ-024 in_valid while in_ready=0 is ignored; no request is queued.
REQ-025 Internal operand, accumulator and counter registers are WIDTH, 2*WIDTH and SHW+1 bits respectively. No intermediate truncation before the final result select.

Reset
REQ-026 rst=1 at a clock edge forces state to IDLE, in a single cycle, in any state including mid-CALC. The following takes effect that edge:
- out_valid=0, in_ready=1
- result=0; all flags 0
- counter and accumulator cleared
REQ-027 An in-flight operation aborted by reset produces no result. The first request after rst deasserts executes normally.
REQ-028 While rst=1, in_valid is ignored.

Verification (WIDTH=32)
REQ-029 ADD a=0x7FFFFFFF, b=1 -> next cycle: out_valid=1, result=0x80000000, overflow=1, negative=1, carry=0, zero=0.
REQ-030 SUB 5-5 -> result 0, zero=1, carry=1. SRA 0x80000000 by b=4 -> 0xF8000000, negative=1.
REQ-031 MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; MULHU same operands -> 0xFFFFFFFE. out_valid first high exactly 33 cycles after accept; in_ready=0 throughout.
REQ-032 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 100/0 -> 0xFFFFFFFF with div_by_zero=1; REMU 100/0 -> 100.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> result and flags stable, in_ready=0, and an in_valid pulse in that window is dropped. Handoff occurs on the first out_ready=1 edge.
REQ-034 Assert rst for 1 cycle at CALC cycle 10 of a DIVU -> next cycle out_valid=0, in_ready=1, result=0. A following ADD 2+3 returns 5 one cycle after accept.
